price_feed_gen: RTL and testbench

Stimulus-side counterpart of matching_engine. It generates the buy_price/sell_price streams that matching_engine consumes. An LFSR-driven random-walk mid price is emitted as non-crossing (buy<sell) quote pairs, with deterministic crossing (buy>sell) pairs injected periodically. It replaces hand-written send_price sequences in on-board and simulation soaks, and flags which pairs must produce match_flag.

---
 rtl/price_feed_gen.sv | 160 ++++++++++++++++
 tb/tb_price_feed_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/price_feed_gen.sv
// Quote-pair stimulus generator for matching_engine: an LFSR random-walk mid price
// emitted as non-crossing pairs, with crossing pairs injected periodically in mode 2'b10.
module price_feed_gen #(
    parameter int          WIDTH       = 8,
    parameter int          MID_INIT    = 75,
    parameter int          HALF_SPREAD = 8,
    parameter int          HOLD_CYCLES = 4,
    parameter int          CROSS_EVERY = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] buy_price,
    output logic [WIDTH-1:0] sell_price,
    output logic             price_valid,
    output logic             new_pair,
    output logic             cross_expected,
    output logic [15:0]      step_count
);

    typedef enum logic [1:0] {
        IDLE,
        QUIET,
        CROSS
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced at elaboration.
    localparam logic [15:0]          SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]          LFSR_MASK = 16'hB400;
    localparam logic [7:0]           HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]           CROSS_CNT = 8'(CROSS_EVERY);
    localparam logic [WIDTH-1:0]     SPREAD    = WIDTH'(HALF_SPREAD);
    localparam logic signed [WIDTH+1:0] MID_LO = (WIDTH+2)'(HALF_SPREAD);
    localparam logic signed [WIDTH+1:0] MID_HI = (WIDTH+2)'((1 << WIDTH) - 1 - HALF_SPREAD);

    state_t             state, state_n;
    logic [WIDTH-1:0]   mid, mid_n;
    logic [15:0]        lfsr, lfsr_n;
    logic [7:0]         hold_cnt, hold_n;
    logic [7:0]         quiet_cnt, quiet_n;
    logic [WIDTH-1:0]   buy_q, buy_n;
    logic [WIDTH-1:0]   sell_q, sell_n;
    logic               valid_q, valid_n;
    logic               new_q, new_n;
    logic               cross_q, cross_n;
    logic [15:0]        steps_q, steps_n;

    logic [1:0]              eff_mode;
    logic                    step;
    logic                    is_cross;
    logic [15:0]             lfsr_adv;
    logic signed [WIDTH+1:0] delta;
    logic signed [WIDTH+1:0] mid_sum;
    logic [WIDTH-1:0]        mid_clamped;

    // Random-walk helpers: next LFSR value and the clamped next mid price.
    always_comb begin
        lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        case (lfsr[1:0])
            2'b00:   delta = (WIDTH+2)'(-2);
            2'b01:   delta = (WIDTH+2)'(-1);
            2'b10:   delta = (WIDTH+2)'(1);
            default: delta = (WIDTH+2)'(2);
        endcase
        mid_sum = $signed({2'b00, mid}) + delta;
        if (mid_sum < MID_LO)
            mid_clamped = MID_LO[WIDTH-1:0];
        else if (mid_sum > MID_HI)
            mid_clamped = MID_HI[WIDTH-1:0];
        else
            mid_clamped = mid_sum[WIDTH-1:0];
    end

    // Next-state and output logic; disabled cycles freeze everything but drop valid.
    always_comb begin
        eff_mode = (mode == 2'b11) ? 2'b01 : mode;
        step     = enable && (eff_mode != 2'b00) && ((state == IDLE) || (hold_cnt == HOLD_LAST));
        is_cross = (eff_mode == 2'b10) && (quiet_cnt == CROSS_CNT);

        state_n = state;
        mid_n   = mid;
        lfsr_n  = lfsr;
        hold_n  = hold_cnt;
        quiet_n = quiet_cnt;
        buy_n   = buy_q;
        sell_n  = sell_q;
        valid_n = 1'b0;
        new_n   = 1'b0;
        cross_n = cross_q;
        steps_n = steps_q;

        if (enable) begin
            if (eff_mode == 2'b00) begin
                state_n = IDLE;
                cross_n = 1'b0;
            end else if (step) begin
                hold_n  = 8'd0;
                valid_n = 1'b1;
                new_n   = 1'b1;
                steps_n = steps_q + 16'd1;
                lfsr_n  = lfsr_adv;
                mid_n   = mid_clamped;
                if (is_cross) begin
                    state_n = CROSS;
                    buy_n   = mid + WIDTH'(1);
                    sell_n  = mid - WIDTH'(1);
                    cross_n = 1'b1;
                    quiet_n = 8'd0;
                end else begin
                    state_n = QUIET;
                    buy_n   = mid - SPREAD;
                    sell_n  = mid + SPREAD;
                    cross_n = 1'b0;
                    quiet_n = (eff_mode == 2'b10) ? quiet_cnt + 8'd1 : 8'd0;
                end
            end else begin
                hold_n  = hold_cnt + 8'd1;
                valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mid       <= WIDTH'(MID_INIT);
            lfsr      <= SEED_EFF;
            hold_cnt  <= 8'd0;
            quiet_cnt <= 8'd0;
            buy_q     <= '0;
            sell_q    <= '0;
            valid_q   <= 1'b0;
            new_q     <= 1'b0;
            cross_q   <= 1'b0;
            steps_q   <= 16'd0;
        end else begin
            state     <= state_n;
            mid       <= mid_n;
            lfsr      <= lfsr_n;
            hold_cnt  <= hold_n;
            quiet_cnt <= quiet_n;
            buy_q     <= buy_n;
            sell_q    <= sell_n;
            valid_q   <= valid_n;
            new_q     <= new_n;
            cross_q   <= cross_n;
            steps_q   <= steps_n;
        end
    end

    assign buy_price      = buy_q;
    assign sell_price     = sell_q;
    assign price_valid    = valid_q;
    assign new_pair       = new_q;
    assign cross_expected = cross_q;
    assign step_count     = steps_q;

endmodule

// File: tb/tb_price_feed_gen.sv
// Self-checking bench for price_feed_gen: four parameterisations share stimulus and are
// checked one at a time against a step-level reference model of the quote rules.
module tb_price_feed_gen;

    localparam int HS = 8;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode   = 2'b00;

    logic [7:0]  buy_p   [4];
    logic [7:0]  sell_p  [4];
    logic        valid_p [4];
    logic        new_p   [4];
    logic        cross_p [4];
    logic [15:0] cnt_p   [4];

    int errors = 0;
    int checks = 0;

    function automatic int hold_of(input int k);
        return (k == 3) ? 1 : 4;
    endfunction

    function automatic int ce_of(input int k);
        return (k == 3) ? 3 : 8;
    endfunction

    function automatic int mid_of(input int k);
        return (k == 1) ? 8 : ((k == 2) ? 247 : 75);
    endfunction

    function automatic logic [15:0] seed_of(input int k);
        return (k == 1) ? 16'h8000 : ((k == 2) ? 16'hFFFF : 16'hACE1);
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        price_feed_gen #(
            .WIDTH(8),
            .MID_INIT(mid_of(g)),
            .HALF_SPREAD(HS),
            .HOLD_CYCLES(hold_of(g)),
            .CROSS_EVERY(ce_of(g)),
            .LFSR_SEED(seed_of(g))
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .enable(enable),
            .mode(mode),
            .buy_price(buy_p[g]),
            .sell_price(sell_p[g]),
            .price_valid(valid_p[g]),
            .new_pair(new_p[g]),
            .cross_expected(cross_p[g]),
            .step_count(cnt_p[g])
        );
    end

    // Reference model state, tracked per step plus a remaining-hold count.
    int          m_mid;
    logic [15:0] m_lfsr;
    int          m_qc;
    logic [15:0] m_steps;
    logic [7:0]  m_buy, m_sell;
    logic        m_valid, m_new, m_cross, m_idle;
    int          m_hold_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_output(input int k);
        check($sformatf("dut%0d buy", k), 32'(buy_p[k]), 32'(m_buy));
        check($sformatf("dut%0d sell", k), 32'(sell_p[k]), 32'(m_sell));
        check($sformatf("dut%0d valid", k), 32'(valid_p[k]), 32'(m_valid));
        check($sformatf("dut%0d new_pair", k), 32'(new_p[k]), 32'(m_new));
        check($sformatf("dut%0d cross", k), 32'(cross_p[k]), 32'(m_cross));
        check($sformatf("dut%0d step_count", k), 32'(cnt_p[k]), 32'(m_steps));
    endtask

    task automatic model_reset(input int k);
        m_mid       = mid_of(k);
        m_lfsr      = seed_of(k);
        m_qc        = 0;
        m_steps     = 16'd0;
        m_buy       = 8'd0;
        m_sell      = 8'd0;
        m_valid     = 1'b0;
        m_new       = 1'b0;
        m_cross     = 1'b0;
        m_idle      = 1'b1;
        m_hold_left = 0;
    endtask

    task automatic model_step(input int k, input logic [1:0] em);
        int d;
        if (em == 2'b10 && m_qc == ce_of(k)) begin
            m_buy   = 8'(m_mid + 1);
            m_sell  = 8'(m_mid - 1);
            m_cross = 1'b1;
            m_qc    = 0;
        end else begin
            m_buy   = 8'(m_mid - HS);
            m_sell  = 8'(m_mid + HS);
            m_cross = 1'b0;
            m_qc    = (em == 2'b10) ? m_qc + 1 : 0;
        end
        d     = int'(m_lfsr[1:0]);
        d     = (d < 2) ? d - 2 : d - 1;
        m_mid = m_mid + d;
        if (m_mid < HS)       m_mid = HS;
        if (m_mid > 255 - HS) m_mid = 255 - HS;
        m_lfsr  = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_steps = m_steps + 16'd1;
    endtask

    task automatic apply_stimulus(input int k, input bit en, input logic [1:0] md);
        logic [1:0] em;
        enable = en;
        mode   = md;
        @(posedge clk);
        #1;
        em = (md == 2'b11) ? 2'b01 : md;
        if (en) begin
            if (em == 2'b00) begin
                m_idle  = 1'b1;
                m_valid = 1'b0;
                m_new   = 1'b0;
                m_cross = 1'b0;
            end else if (m_idle || m_hold_left == 0) begin
                model_step(k, em);
                m_idle      = 1'b0;
                m_valid     = 1'b1;
                m_new       = 1'b1;
                m_hold_left = hold_of(k) - 1;
            end else begin
                m_hold_left--;
                m_valid = 1'b1;
                m_new   = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            m_new   = 1'b0;
        end
        check_output(k);
    endtask

    task automatic do_reset(input int k);
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        model_reset(k);
        check_output(k);
        reset = 1'b0;
    endtask

    initial begin
        bit         en;
        logic [1:0] md;

        $display("[TB] quiet stream, default parameters");
        do_reset(0);
        apply_stimulus(0, 1'b1, 2'b01);
        check("first_buy", 32'(buy_p[0]), 32'd67);
        check("first_sell", 32'(sell_p[0]), 32'd83);
        check("first_count", 32'(cnt_p[0]), 32'd1);
        while (m_steps < 16'd50) begin
            apply_stimulus(0, 1'b1, 2'b01);
            if (m_new) check("quiet_order", 32'(buy_p[0] < sell_p[0]), 32'd1);
        end

        $display("[TB] periodic crossing in mode 10");
        do_reset(0);
        while (m_steps < 16'd40) begin
            apply_stimulus(0, 1'b1, 2'b10);
            if (m_new) begin
                check("cross_slot", 32'(cross_p[0]), 32'(m_steps % 9 == 0));
                if (m_steps % 9 == 0)
                    check("cross_gap", 32'(8'(buy_p[0] - sell_p[0])), 32'd2);
            end
        end

        $display("[TB] enable freeze at hold_cnt=2");
        apply_stimulus(0, 1'b1, 2'b10);
        apply_stimulus(0, 1'b1, 2'b10);
        repeat (10) apply_stimulus(0, 1'b0, 2'b10);
        apply_stimulus(0, 1'b1, 2'b10);
        check("resume_hold", 32'(new_p[0]), 32'd0);
        apply_stimulus(0, 1'b1, 2'b10);
        check("resume_step", 32'(new_p[0]), 32'd1);

        $display("[TB] random enable and mode");
        repeat (120) begin
            en = ($urandom_range(0, 3) != 0);
            md = 2'($urandom_range(1, 3));
            apply_stimulus(0, en, md);
        end

        $display("[TB] idle mode interlude");
        repeat (3) apply_stimulus(0, 1'b1, 2'b00);
        check("idle_valid", 32'(valid_p[0]), 32'd0);
        apply_stimulus(0, 1'b1, 2'b10);
        check("idle_exit_new", 32'(new_p[0]), 32'd1);
        repeat (60) apply_stimulus(0, 1'b1, 2'b10);

        $display("[TB] lower clamp");
        do_reset(1);
        repeat (150) begin
            en = ($urandom_range(0, 4) != 0);
            apply_stimulus(1, en, 2'b01);
            if (m_valid) check("low_bound", 32'(buy_p[1] < 8'd248), 32'd1);
        end

        $display("[TB] upper clamp");
        do_reset(2);
        repeat (150) begin
            en = ($urandom_range(0, 4) != 0);
            apply_stimulus(2, en, 2'b01);
            if (m_valid) check("high_bound", 32'(sell_p[2] > buy_p[2]), 32'd1);
        end

        $display("[TB] async reset during cross pair");
        do_reset(3);
        repeat (4) apply_stimulus(3, 1'b1, 2'b10);
        check("pre_reset_cross", 32'(cross_p[3]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset(3);
        check_output(3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(3, 1'b1, 2'b10);
        check("rerun_buy", 32'(buy_p[3]), 32'd67);
        check("rerun_sell", 32'(sell_p[3]), 32'd83);
        repeat (20) apply_stimulus(3, 1'b1, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
